mux_scan_capture: RTL and testbench
===================================

# mux_scan_capture

Sequential front-end controller for the 16:1 multiplexer tree. On a start request, the block walks the mux select lines through every input index and samples the single-bit mux output `z` after a configurable settle time. It then assembles the 16 samples into a parallel word and hands that word downstream over a valid/ready handshake. The block sits directly upstream of the mux select input and directly downstream of its `Z` output, turning the combinational selector into a timed parallel-capture stage.

## Interface
- `N`, 16: number of mux inputs scanned; must equal 2**`SEL_W`.
- `SEL_W`, 4: select width driven to the mux.
- `SETTLE`, 1: idle cycles after each select change before sampling `z`; legal range 0..15.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  scan request; accepted only in IDLE.
- `z`  in  1  mux output for the currently driven select.
- `sel`  out  `SEL_W`  mux select; registered.
- `busy`  out  1  high in SCAN and HOLD.
- `out_valid`  out  1  captured word available.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  `N`  captured word; bit k = `z` sampled while `sel`==k.
- `out_parity`  out  1  present only with `MUX_SCAN_PARITY_EN`; XOR of `out_data`.

## Operation
- FSM has three states: IDLE, SCAN and HOLD. Encoding is in the package.
- **IDLE**
  - `start`=1 transitions to SCAN.
  - On that transition, `sel`←0, settle counter `cnt`←0 and `out_data`←0.
- **SCAN**, evaluated each cycle:
  - If `cnt`==`SETTLE`: `out_data[sel]`←`z` and `cnt`←0.
  - On that capture, if `sel`==N-1 then `sel`←0 and the FSM transitions to HOLD; otherwise `sel`←`sel`+1.
  - Otherwise `cnt`←`cnt`+1.
- **HOLD**
  - `out_valid`=1. `out_data` and `out_parity` are held stable.
  - `out_valid`&&`out_ready` completes the transfer and returns to IDLE. `out_data` is retained until the next accepted start.
- `start` in SCAN or HOLD is ignored and not queued.
- `start` in the same cycle as the HOLD→IDLE transfer is ignored; it must be reasserted in IDLE.
- `out_ready` outside HOLD has no effect.
- `sel` never exceeds N-1; no wrap occurs within a scan.

## Timing
- Reset values:
  - FSM: IDLE.
  - `sel`, `cnt`, `out_data`: 0.
  - `busy`, `out_valid`, `out_parity`: 0.
- Reset mid-scan or mid-hold aborts immediately; the partial word is discarded.
- Each index occupies `SETTLE`+1 cycles of SCAN.
- `out_valid` rises N*(`SETTLE`+1) cycles after the start-accept edge. With the defaults this is 32 cycles.
- `busy` rises on the start-accept edge and falls on the transfer edge.
- `out_valid` is registered; zero-cycle pass-through is not permitted.
- Minimum start-to-start period is N*(`SETTLE`+1)+2 cycles, with `out_ready` held high.

## Configuration
- `MUX_SCAN_PARITY_EN` defined:
  - `out_parity` port exists.
  - It is registered and updated with each captured bit (running XOR), cleared at start accept.
  - Its value is valid whenever `out_valid`=1.
- Not defined: the port and parity logic are absent; all other behaviour is identical.

## Structure
- Shared package `mux_scan_pkg` holds:
  - the FSM state typedef (IDLE, SCAN, HOLD);
  - the default `N`, `SEL_W`, `SETTLE` constants;
  - the `cnt` width constant (4 bits).
- One sub-module, `mux_scan_settle_ctr`: settle counter with clear, increment and terminal-count flag (`cnt`==`SETTLE`).
- FSM, select register and capture register stay in the top module.

## Test plan
- **Full scan:** bench mux model with inputs 16'hA5C3 and `start` pulsed for 1 cycle. Required response: `sel` steps 0..15 with each value held 2 cycles; `out_valid` rises 32 cycles after accept; `out_data`=16'hA5C3.
- **Backpressure:** `out_ready`=0 for 5 cycles in HOLD, inputs changed to 16'hFFFF. Required response: `out_valid` stays 1, `out_data` stays 16'hA5C3; transfer completes on the first `out_ready`=1 cycle.
- **Ignored start:** `start` pulsed at cycle 10 of a scan and again during HOLD. Required response: `sel` sequence is undisturbed and no extra scan follows the transfer.
- **Reset mid-scan:** `rst_n` asserted low at scan cycle 12. Required response: `sel`=0, `busy`=0, `out_data`=0 immediately; a new scan of 16'h0F0F after release yields 16'h0F0F.
- **SETTLE=0:** inputs 16'h8001. Required response: `out_valid` rises 16 cycles after accept, `out_data`=16'h8001.
- **Parity (`MUX_SCAN_PARITY_EN`):** inputs 16'h0001 give `out_parity`=1; inputs 16'hA5C3 give `out_parity`=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan capture block.
// FSM encoding, default geometry and settle counter width.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int N_DEF      = 16;
  localparam int SEL_W_DEF  = 4;
  localparam int SETTLE_DEF = 1;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mux_scan_settle_ctr.sv
// Settle counter for the mux scan: clear, increment, terminal flag.
// tc marks the cycle in which z is sampled.
module mux_scan_settle_ctr
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  // Count settle cycles; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal count once the settle time has elapsed.
  always_comb begin
    tc = (cnt == CNT_W'(SETTLE));
  end

endmodule

// File: rtl/mux_scan_capture.sv
// Walks the mux select through all inputs and captures z into a word.
// Optional running parity on out_parity with MUX_SCAN_PARITY_EN.
module mux_scan_capture
  import mux_scan_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             z,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic [N-1:0]     out_data,
  output logic             out_parity
`else
  output logic [N-1:0]     out_data
`endif
);

  state_t state;
  state_t state_n;
  logic   tc;
  logic   accept;
  logic   capture;
  logic   last;

  // Datapath strobes derived from the current state.
  always_comb begin
    accept  = (state == IDLE) && start;
    capture = (state == SCAN) && tc;
    last    = (sel == SEL_W'(N - 1));
  end

  mux_scan_settle_ctr #(
    .SETTLE (SETTLE)
  ) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || capture),
    .inc   ((state == SCAN) && !tc),
    .tc    (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SCAN;
      SCAN:    if (tc && last) state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Select register steps once per capture, never past N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
    end else if (accept) begin
      sel <= '0;
    end else if (capture) begin
      sel <= last ? '0 : sel + 1'b1;
    end
  end

  // Capture word; kept after transfer until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (accept) begin
      out_data <= '0;
    end else if (capture) begin
      out_data[sel] <= z;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // Running XOR of captured bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= 1'b0;
    end else if (capture) begin
      out_parity <= out_parity ^ z;
    end
  end
`endif

  // Status outputs decoded from the registered state.
  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == HOLD);
  end

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture: default and SETTLE=0 instances.
// Each DUT is fed by a behavioural 16:1 mux model.
module tb_mux_scan_capture;

  logic        clk;
  logic        rst_n;

  logic        start;
  logic        ready;
  logic [15:0] din;
  logic        z;
  logic [3:0]  sel;
  logic        busy;
  logic        valid;
  logic [15:0] data;

  logic        start0;
  logic        ready0;
  logic [15:0] din0;
  logic        z0;
  logic [3:0]  sel0;
  logic        busy0;
  logic        valid0;
  logic [15:0] data0;

`ifdef MUX_SCAN_PARITY_EN
  logic        par;
  logic        par0;
`endif

  int passed;
  int total;

  assign z  = din[sel];
  assign z0 = din0[sel0];

  mux_scan_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .z         (z),
    .sel       (sel),
    .busy      (busy),
    .out_valid (valid),
    .out_ready (ready),
`ifdef MUX_SCAN_PARITY_EN
    .out_data  (data),
    .out_parity(par)
`else
    .out_data  (data)
`endif
  );

  mux_scan_capture #(
    .SETTLE (0)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .z         (z0),
    .sel       (sel0),
    .busy      (busy0),
    .out_valid (valid0),
    .out_ready (ready0),
`ifdef MUX_SCAN_PARITY_EN
    .out_data  (data0),
    .out_parity(par0)
`else
    .out_data  (data0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    ready  = 1'b0;
    din    = 16'hA5C3;
    start0 = 1'b0;
    ready0 = 1'b1;
    din0   = 16'h8001;
    #12;

    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    check("rst_par", 32'(par), 32'd0);
`endif

    rst_n = 1'b1;
    tick();

    // Full scan of A5C3 with a stray start at scan cycle 10
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("scan_sel%0d", i), 32'(sel), 32'(i / 2));
      check($sformatf("scan_nv%0d", i), 32'(valid), 32'd0);
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    check("hold_valid", 32'(valid), 32'd1);
    check("hold_data", 32'(data), 32'hA5C3);
    check("hold_sel", 32'(sel), 32'd0);
    check("hold_busy", 32'(busy), 32'd1);
`ifdef MUX_SCAN_PARITY_EN
    check("par_a5c3", 32'(par), 32'd0);
`endif

    // Backpressure with changed inputs and a start during HOLD
    din = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      check($sformatf("bp_valid%0d", i), 32'(valid), 32'd1);
      check($sformatf("bp_data%0d", i), 32'(data), 32'hA5C3);
    end
    start = 1'b0;

    // Transfer edge with start asserted: start must be ignored
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("xfer_valid", 32'(valid), 32'd0);
    check("xfer_busy", 32'(busy), 32'd0);
    check("xfer_data", 32'(data), 32'hA5C3);
    tick();
    tick();
    check("no_rescan_busy", 32'(busy), 32'd0);
    check("no_rescan_sel", 32'(sel), 32'd0);
    check("retain_data", 32'(data), 32'hA5C3);

    // Reset at scan cycle 12 of a 0F0F scan
    din   = 16'h0F0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("mid_sel", 32'(sel), 32'd6);
    check("mid_data", 32'(data), 32'h000F);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", 32'(data), 32'd0);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    check("rescan_nv", 32'(valid), 32'd0);
    tick();
    check("rescan_valid", 32'(valid), 32'd1);
    check("rescan_data", 32'(data), 32'h0F0F);
    tick();
    check("rescan_done", 32'(busy), 32'd0);

    // SETTLE=0 instance: valid after 16 cycles
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("s0_sel%0d", i), 32'(sel0), 32'(i));
      check($sformatf("s0_nv%0d", i), 32'(valid0), 32'd0);
      if (i < 15) tick();
    end
    tick();
    check("s0_valid", 32'(valid0), 32'd1);
    check("s0_data", 32'(data0), 32'h8001);
`ifdef MUX_SCAN_PARITY_EN
    check("par_8001", 32'(par0), 32'd0);
`endif
    tick();
    check("s0_idle", 32'(busy0), 32'd0);

    // Parity-only pattern on the fast instance
    din0   = 16'h0001;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("s0_data1", 32'(data0), 32'h0001);
`ifdef MUX_SCAN_PARITY_EN
    check("par_0001", 32'(par0), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
